// File: rtl/trng_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trng_sequencer
// Brief    : Ring-oscillator entropy controller: warm-up, divided sampling,
//            von-Neumann debias, word packing and repetition-count health test.
// Revision : 1.0
// ============================================================================
module trng_sequencer #(
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 4,
    parameter int REP_LIMIT     = 16,
    parameter int WORD_W        = 8
) (
    input  logic              i_clk,
    input  logic              i_resSync,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_rawRandom,
    input  logic              i_chainReady,
    output logic              o_enSim,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_healthFail
);

    localparam int c_WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int c_DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_REP_W  = $clog2(REP_LIMIT + 1);
    localparam int c_BIT_W  = $clog2(WORD_W + 1);

    localparam logic [c_WARM_W-1:0] c_WARM_LAST = c_WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SAMPLE_DIV - 1);
    localparam logic [c_REP_W-1:0]  c_REP_LIMIT = c_REP_W'(REP_LIMIT);
    localparam logic [c_REP_W-1:0]  c_REP_ONE   = c_REP_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WORD_W - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WARMUP = 3'd1;
    localparam logic [2:0] c_ST_SAMPLE = 3'd2;
    localparam logic [2:0] c_ST_HOLD   = 3'd3;
    localparam logic [2:0] c_ST_FAIL   = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [c_WARM_W-1:0] r_warm_cnt;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_REP_W-1:0]  r_rep_cnt;
    logic                r_prev;
    logic                r_have_first;
    logic                r_first;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0]   r_shift;
    logic [WORD_W-1:0]   r_data;
    logic                r_health_fail;

    logic                w_start_ok;
    logic                w_sample_tick;
    logic [c_REP_W-1:0]  w_rep_next;
    logic                w_rep_fail;
    logic                w_bit_valid;
    logic                w_word_done;
    logic [WORD_W-1:0]   w_shift_next;

    assign w_start_ok    = i_start && !i_stop;
    assign w_sample_tick = (r_state == c_ST_SAMPLE) && (r_div == c_DIV_LAST);
    // A zero rep count means no sample has been seen since entering SAMPLE.
    assign w_rep_next    = ((r_rep_cnt == '0) || (i_rawRandom != r_prev)) ? c_REP_ONE
                                                                          : r_rep_cnt + c_REP_ONE;
    assign w_rep_fail    = w_sample_tick && (w_rep_next == c_REP_LIMIT);
    assign w_bit_valid   = w_sample_tick && r_have_first && (r_first != i_rawRandom);
    assign w_word_done   = w_bit_valid && (r_bit_cnt == c_BIT_LAST);
    // Accepted bits enter at the MSB so the first one ends up in bit 0.
    assign w_shift_next  = (r_shift >> 1) | (WORD_W'(r_first) << (WORD_W - 1));

    always_ff @(posedge i_clk) begin
        if (i_resSync) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok) w_state_next = c_ST_WARMUP;
            end
            c_ST_WARMUP: begin
                if (i_stop)                          w_state_next = c_ST_IDLE;
                else if (r_warm_cnt == c_WARM_LAST)  w_state_next = i_chainReady ? c_ST_SAMPLE : c_ST_FAIL;
            end
            c_ST_SAMPLE: begin
                if (i_stop)           w_state_next = c_ST_IDLE;
                else if (w_rep_fail)  w_state_next = c_ST_FAIL;
                else if (w_word_done) w_state_next = c_ST_HOLD;
            end
            c_ST_HOLD: begin
                if (i_stop)       w_state_next = c_ST_IDLE;
                else if (i_ready) w_state_next = c_ST_SAMPLE;
            end
            c_ST_FAIL: begin
                if (i_stop)       w_state_next = c_ST_IDLE;
                else if (i_start) w_state_next = c_ST_WARMUP;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_enSim = 1'b0;
        o_busy  = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            c_ST_WARMUP, c_ST_SAMPLE: begin
                o_enSim = 1'b1;
                o_busy  = 1'b1;
            end
            c_ST_HOLD: begin
                o_enSim = 1'b1;
                o_busy  = 1'b1;
                o_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_data       = r_data;
    assign o_healthFail = r_health_fail;

    always_ff @(posedge i_clk) begin
        if (i_resSync) begin
            r_warm_cnt    <= '0;
            r_div         <= '0;
            r_rep_cnt     <= '0;
            r_prev        <= 1'b0;
            r_have_first  <= 1'b0;
            r_first       <= 1'b0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_health_fail <= 1'b0;
        end else begin
            if ((r_state == c_ST_WARMUP) && (r_warm_cnt != c_WARM_LAST)) r_warm_cnt <= r_warm_cnt + 1'b1;
            else                                                          r_warm_cnt <= '0;

            if ((r_state != c_ST_FAIL) && (w_state_next == c_ST_FAIL))
                r_health_fail <= 1'b1;
            else if (((r_state == c_ST_IDLE) || (r_state == c_ST_FAIL)) && w_start_ok)
                r_health_fail <= 1'b0;

            // Sampling context is rebuilt every warm-up, so stop/fail need no cleanup.
            if (r_state == c_ST_WARMUP) begin
                r_div        <= '0;
                r_rep_cnt    <= '0;
                r_prev       <= 1'b0;
                r_have_first <= 1'b0;
                r_first      <= 1'b0;
                r_bit_cnt    <= '0;
                r_shift      <= '0;
            end else if (r_state == c_ST_SAMPLE) begin
                r_div <= w_sample_tick ? '0 : r_div + 1'b1;
                if (w_sample_tick) begin
                    r_rep_cnt    <= w_rep_next;
                    r_prev       <= i_rawRandom;
                    r_have_first <= !r_have_first;
                    if (!r_have_first) r_first <= i_rawRandom;
                end
                if (w_bit_valid) begin
                    r_shift   <= w_shift_next;
                    r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + 1'b1;
                end
                if (w_word_done && (w_state_next == c_ST_HOLD)) r_data <= w_shift_next;
            end
        end
    end

endmodule
`default_nettype wire
